pwm_deadtime: RTL and testbench

- Gate-drive stage directly downstream of svpwm.
- Converts the three single-ended phase commands (pwm_a/b/c) plus pwm_en into complementary high-side/low-side gate signals with guaranteed dead time.
- Includes a sticky fault shutdown.
- Outputs drive the FPGA pins to the half-bridge drivers; every output is registered.

---
 rtl/pwm_deadtime.sv | 180 ++++++++++++++++++
 tb/tb_pwm_deadtime.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_deadtime.sv
// -----------------------------------------------------------------------------
// pwm_deadtime
//
// Gate-drive stage that sits directly after the space-vector modulator. It
// turns the three single-ended phase commands into complementary high-side /
// low-side gate signals and inserts a dead time at every handover. A sticky
// fault latch forces the whole bridge off until software acknowledges it.
//
// Ports
//   clk      in   system clock (36.864 MHz nominal)
//   rstn     in   asynchronous active-low reset, released synchronously
//   pwm_en   in   1 = bridge may conduct
//   pwm_a/b/c in  phase commands, 1 = high side on, 0 = low side on
//   i_fault  in   external overcurrent / driver fault, active high, already
//                 synchronous to clk
//   pwm_ah/al out phase A high-side / low-side gate (registered)
//   pwm_bh/bl out phase B high-side / low-side gate (registered)
//   pwm_ch/cl out phase C high-side / low-side gate (registered)
//   o_fault  out  sticky fault flag (registered)
//
// Parameters
//   DEADTIME  dead time in clk cycles, legal range 1..1023
//             (37 is about 1.0 us at 36.864 MHz)
//
// Per-phase FSM
//   OFF  : both gates low; leaves to DEAD as soon as the bridge is gated on.
//   DEAD : both gates low for DEADTIME edges; the phase command is sampled
//          only on the exit edge, so toggles inside the window are ignored.
//   ON_H : high side conducts until the command falls.
//   ON_L : low side conducts until the command rises.
//   Any edge where the bridge is not gated on forces OFF and clears the
//   counter, so a re-enable always pays the full dead time.
//
// The FSM state of each phase lives in g_phase[n].r_state / g_phase[n].r_cnt
// with regular names so it can be probed hierarchically.
// -----------------------------------------------------------------------------
module pwm_deadtime #(
  parameter int DEADTIME = 37
) (
  input  logic clk,
  input  logic rstn,
  input  logic pwm_en,
  input  logic pwm_a,
  input  logic pwm_b,
  input  logic pwm_c,
  input  logic i_fault,
  output logic pwm_ah,
  output logic pwm_al,
  output logic pwm_bh,
  output logic pwm_bl,
  output logic pwm_ch,
  output logic pwm_cl,
  output logic o_fault
);

  // Counter width is derived from DEADTIME and is not meant to be overridden.
  localparam int CW = $clog2(DEADTIME + 1);

  // Counter load value on DEAD entry: DEAD lasts for the entry edge plus
  // DEADTIME-1 decrementing edges, so the opposite side turns on exactly
  // DEADTIME edges after the turn-off edge.
  localparam logic [CW-1:0] DT_LOAD = CW'(DEADTIME - 1);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_DEAD = 2'd1,
    ST_ON_H = 2'd2,
    ST_ON_L = 2'd3
  } phase_state_t;

  logic       r_fault;
  logic       w_fault_now;
  logic       w_gate;
  logic [2:0] w_cmd;
  logic [2:0] w_gate_h;
  logic [2:0] w_gate_l;

  assign w_cmd = {pwm_c, pwm_b, pwm_a};

  // A fault sampled on this edge must already shut the phases off on this
  // same edge, hence the OR with the live input rather than the latch alone.
  assign w_fault_now = i_fault | r_fault;
  assign w_gate      = pwm_en & ~w_fault_now;

  // Sticky fault latch. Set has priority; clearing needs an edge with the
  // fault input low and the bridge disabled, so the modulator has to
  // acknowledge the fault before conduction can resume.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_fault <= 1'b0;
    end else if (i_fault) begin
      r_fault <= 1'b1;
    end else if (!pwm_en) begin
      r_fault <= 1'b0;
    end
  end

  assign o_fault = r_fault;

  for (genvar gi = 0; gi < 3; gi++) begin : g_phase
    phase_state_t    r_state;
    phase_state_t    w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            r_h;
    logic            r_l;

    // Next-state logic. Losing the gate wins over every other condition,
    // including a direction change or a running dead-time count.
    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      if (!w_gate) begin
        w_state_nxt = ST_OFF;
        w_cnt_nxt   = '0;
      end else begin
        case (r_state)
          ST_OFF: begin
            w_state_nxt = ST_DEAD;
            w_cnt_nxt   = DT_LOAD;
          end
          ST_ON_H: begin
            if (!w_cmd[gi]) begin
              w_state_nxt = ST_DEAD;
              w_cnt_nxt   = DT_LOAD;
            end
          end
          ST_ON_L: begin
            if (w_cmd[gi]) begin
              w_state_nxt = ST_DEAD;
              w_cnt_nxt   = DT_LOAD;
            end
          end
          ST_DEAD: begin
            if (r_cnt != '0) begin
              w_cnt_nxt = r_cnt - 1'b1;
            end else begin
              // Command is sampled only here; a phase may legally return
              // to the side it left if a short pulse was absorbed.
              w_state_nxt = w_cmd[gi] ? ST_ON_H : ST_ON_L;
              w_cnt_nxt   = '0;
            end
          end
          default: begin
            w_state_nxt = ST_OFF;
            w_cnt_nxt   = '0;
          end
        endcase
      end
    end

    // Gates are registered from the next state so they change on the same
    // edge as the state itself; H and L decode from distinct states and so
    // can never be high together.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        r_state <= ST_OFF;
        r_cnt   <= '0;
        r_h     <= 1'b0;
        r_l     <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_h     <= (w_state_nxt == ST_ON_H);
        r_l     <= (w_state_nxt == ST_ON_L);
      end
    end

    assign w_gate_h[gi] = r_h;
    assign w_gate_l[gi] = r_l;
  end

  assign pwm_ah = w_gate_h[0];
  assign pwm_al = w_gate_l[0];
  assign pwm_bh = w_gate_h[1];
  assign pwm_bl = w_gate_l[1];
  assign pwm_ch = w_gate_h[2];
  assign pwm_cl = w_gate_l[2];

endmodule

// File: tb/tb_pwm_deadtime.sv
// -----------------------------------------------------------------------------
// tb_pwm_deadtime
//
// Directed bench for pwm_deadtime with DEADTIME=4, followed by a randomised
// stretch watched by always-on invariant monitors (no shoot-through, minimum
// dead time at every turn-on, outputs off while disabled or faulted).
// Output vector layout used throughout: {o_fault, ah, al, bh, bl, ch, cl}.
// -----------------------------------------------------------------------------
module tb_pwm_deadtime;

  localparam int DT = 4;

  localparam logic [6:0] F  = 7'b1000000;
  localparam logic [6:0] AH = 7'b0100000;
  localparam logic [6:0] AL = 7'b0010000;
  localparam logic [6:0] BH = 7'b0001000;
  localparam logic [6:0] BL = 7'b0000100;
  localparam logic [6:0] CH = 7'b0000010;
  localparam logic [6:0] CL = 7'b0000001;
  localparam logic [6:0] Z  = 7'b0000000;

  logic clk;
  logic rstn;
  logic pwm_en;
  logic pwm_a;
  logic pwm_b;
  logic pwm_c;
  logic i_fault;
  logic pwm_ah;
  logic pwm_al;
  logic pwm_bh;
  logic pwm_bl;
  logic pwm_ch;
  logic pwm_cl;
  logic o_fault;

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] exp_q[$];

  pwm_deadtime #(.DEADTIME(DT)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .pwm_en  (pwm_en),
    .pwm_a   (pwm_a),
    .pwm_b   (pwm_b),
    .pwm_c   (pwm_c),
    .i_fault (i_fault),
    .pwm_ah  (pwm_ah),
    .pwm_al  (pwm_al),
    .pwm_bh  (pwm_bh),
    .pwm_bl  (pwm_bl),
    .pwm_ch  (pwm_ch),
    .pwm_cl  (pwm_cl),
    .o_fault (o_fault)
  );

  // ---------------------------------------------------------------- clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // -------------------------------------------------------------- helpers
  function automatic logic [6:0] outs();
    return {o_fault, pwm_ah, pwm_al, pwm_bh, pwm_bl, pwm_ch, pwm_cl};
  endfunction

  task automatic drive(input logic en, input logic a, input logic b,
                       input logic c, input logic f);
    pwm_en  = en;
    pwm_a   = a;
    pwm_b   = b;
    pwm_c   = c;
    i_fault = f;
  endtask

  task automatic check_pop(input string tag, input logic [6:0] obs);
    logic [6:0] e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: observed=%b but expected queue is empty", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s: observed=%b expected=%b", tag, obs, e);
      end
    end
  endtask

  // Push the expectation for the coming edge, then compare 1 ns after it.
  task automatic cyc(input logic [6:0] e, input string tag);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check_pop(tag, outs());
  endtask

  // Compare immediately (used for asynchronous reset effects).
  task automatic check_now(input logic [6:0] e, input string tag);
    exp_q.push_back(e);
    check_pop(tag, outs());
  endtask

  // ------------------------------------------------------------- monitors
  logic       m_en;
  logic       m_f;
  logic       m_rst;
  logic [2:0] mh;
  logic [2:0] ml;
  logic [2:0] prev_h = 3'b000;
  logic [2:0] prev_l = 3'b000;
  int         low_cnt[3];

  initial begin
    for (int p = 0; p < 3; p++) low_cnt[p] = 0;
  end

  always @(posedge clk) begin
    m_en  = pwm_en;
    m_f   = i_fault;
    m_rst = rstn;
    #1;
    mh = {pwm_ch, pwm_bh, pwm_ah};
    ml = {pwm_cl, pwm_bl, pwm_al};
    if (!m_rst) begin
      for (int p = 0; p < 3; p++) low_cnt[p] = 0;
      prev_h = 3'b000;
      prev_l = 3'b000;
    end else begin
      for (int p = 0; p < 3; p++) begin
        n_checks++;
        assert ((mh[p] & ml[p]) === 1'b0) else begin
          n_fail++;
          $error("FAIL shoot_through phase %0d: h=%b l=%b required not both 1",
                 p, mh[p], ml[p]);
        end
        if (mh[p] | ml[p]) begin
          // Newly conducting or switched side: needs a full low gap first.
          if ((mh[p] !== prev_h[p]) || (ml[p] !== prev_l[p])) begin
            n_checks++;
            assert ((low_cnt[p] >= DT) === 1'b1) else begin
              n_fail++;
              $error("FAIL dead_gap phase %0d: low cycles=%0d required>=%0d",
                     p, low_cnt[p], DT);
            end
          end
          low_cnt[p] = 0;
        end else begin
          low_cnt[p]++;
        end
      end
      prev_h = mh;
      prev_l = ml;
      if (!m_en) begin
        n_checks++;
        assert ((mh | ml) === 3'b000) else begin
          n_fail++;
          $error("FAIL en_low_gates: h=%b l=%b required all 0", mh, ml);
        end
      end
      if (m_f) begin
        n_checks++;
        assert (outs() === F) else begin
          n_fail++;
          $error("FAIL fault_shutdown: observed=%b expected=%b", outs(), F);
        end
      end
    end
  end

  // ------------------------------------------------------------- stimulus
  initial begin
    rstn = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_now(Z, "reset");
    rstn = 1'b1;
    cyc(Z, "idle_en0");
    cyc(Z, "idle_en0");

    // Enable rising: DEAD entered on the first enabled edge, conduction on
    // the DT+1-th edge counting that one. Phases start on different sides.
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < DT; i++) cyc(Z, "en_rise_dead");
    cyc(AH | BL | CH, "en_rise_on");
    cyc(AH | BL | CH, "hold");
    cyc(AH | BL | CH, "hold");

    // Handover both ways at once: a H->L, b L->H; c untouched.
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < DT; i++) cyc(CH, "handover_dead");
    cyc(AL | BH | CH, "handover_on");
    cyc(AL | BH | CH, "handover_hold");

    // 2-cycle pulse on a while in ON_L: low side off DT cycles then back on.
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc(BH | CH, "pulse_dead");
    cyc(BH | CH, "pulse_dead");
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(BH | CH, "pulse_dead");
    cyc(BH | CH, "pulse_dead");
    cyc(AL | BH | CH, "pulse_return");
    cyc(AL | BH | CH, "pulse_hold");

    // c leaves ON_H; it toggles inside DEAD and is 0 at the exit edge.
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(AL | BH, "toggle_dead");
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(AL | BH, "toggle_dead");
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(AL | BH, "toggle_dead");
    cyc(AL | BH, "toggle_dead");
    cyc(AL | BH | CL, "toggle_exit");

    // One-cycle fault while all phases conduct, with a direction change on
    // the same edge. Latch holds with pwm_en=1 and clears once disabled.
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    cyc(F, "fault_set");
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(F, "fault_sticky");
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(Z, "fault_clear");
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < DT; i++) cyc(Z, "reen_dead");
    cyc(AH | BH | CL, "reen_on");

    // Clearing needs i_fault low as well as pwm_en low.
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    cyc(F, "fault_hold_en0");
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(Z, "fault_clear2");
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < DT; i++) cyc(Z, "reen1_dead");
    cyc(AH | BH | CL, "reen1_on");

    // pwm_en drops mid-DEAD: the partial count must not shorten re-entry.
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(BH | CL, "pre_drop_dead");
    cyc(BH | CL, "pre_drop_dead");
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(Z, "en_drop_dead");
    cyc(Z, "en_drop_dead");
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < DT; i++) cyc(Z, "reen2_dead");
    cyc(AL | BH | CL, "reen2_on");

    // Reset asserted between edges with a in DEAD and b in ON_H.
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(BH | CL, "pre_reset");
    #2;
    rstn = 1'b0;
    #1;
    check_now(Z, "async_reset");
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(Z, "in_reset");
    rstn = 1'b1;
    for (int i = 0; i < DT; i++) cyc(Z, "rst_release_dead");
    cyc(AH | BL | CH, "rst_release_on");

    // Randomised run; the monitors carry the checking here.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        pwm_a = 1'($urandom_range(0, 1));
        pwm_b = 1'($urandom_range(0, 1));
        pwm_c = 1'($urandom_range(0, 1));
      end
      pwm_en  = ($urandom_range(0, 99) != 0);
      i_fault = ($urandom_range(0, 299) == 0);
      @(posedge clk);
      #1;
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(Z, "final_off");

    n_checks++;
    assert (exp_q.size() === 0) else begin
      n_fail++;
      $error("FAIL queue_drain: left=%0d required=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
